// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding and default bus geometry for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [DEF_DW/8-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    IBUSY = 2'b01,
    DBUSY = 2'b10
  } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for one outstanding memory access (only instantiated with MEM_ARB_TIMEOUT_EN).
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + CW'(1);
  end

  // Fires on the stalled cycle whose increment would bring the count to TIMEOUT.
  assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data memory; data wins ties.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that see no mem_ready within TIMEOUT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_valid,
  input  logic            data_req,
  input  logic            data_we,
  input  logic [DW/8-1:0] data_be,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_valid,
  output logic            stallF,
  output logic            stallM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            err
);

  state_t state, state_next;
  logic   grant_data, grant_inst, done, expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (data_req) begin
          grant_data = 1'b1;
          state_next = DBUSY;
        end else if (inst_req) begin
          grant_inst = 1'b1;
          state_next = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready || expire) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign stallF = inst_req & ~inst_valid;
  assign stallM = data_req & ~data_valid;

  // Bus outputs are captured once at grant and held until the access finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      if (grant_data) begin
        mem_req   <= 1'b1;
        mem_we    <= data_we;
        mem_be    <= data_be;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else if (grant_inst) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_be   <= '1;
        mem_addr <= inst_addr;
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (state == IBUSY) begin
          inst_valid <= 1'b1;
          inst_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          data_valid <= 1'b1;
          if (!mem_ready)
            data_rdata <= '0;
          else if (!mem_we)
            data_rdata <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic busy;

  assign busy = (state == IBUSY) || (state == DBUSY);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_data | grant_inst),
    .enable (busy & ~mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else
      err <= expire;
  end
`else
  // Without the watchdog an access waits for mem_ready indefinitely.
  localparam bit TIMEOUT_SET = (TIMEOUT != 0);

  assign expire = TIMEOUT_SET & 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level bus-ownership model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_LIM   = 4;
  localparam int MAX_WAIT = 6;
`else
  localparam int TO_LIM   = 0;
  localparam int MAX_WAIT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_rdata;
  logic          inst_valid;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [BW-1:0] data_be = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] data_rdata;
  logic          data_valid;
  logic          stallF, stallM;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          err;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT((TO_LIM == 0) ? 255 : TO_LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .stallF(stallF), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns the bus (0 none, 1 fetch, 2 data) and what was captured at grant.
  int            owner;
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [BW-1:0] cap_be;
  logic [DW-1:0] cap_wdata;
  logic          exp_iv, exp_dv, exp_err;
  logic [DW-1:0] exp_ird, exp_drd;
  int            wait_left, stalled;
  int            forced_wait = -1;
  logic          force_rd_en = 1'b0;
  logic [DW-1:0] force_rd = '0;
  int            reqhi_seen, ivalid_seen, dvalid_seen, err_seen;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq,
                               input logic dwe, input logic [BW-1:0] dbe, input logic [AW-1:0] daddr,
                               input logic [DW-1:0] dwdata);
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_we    = dwe;
    data_be    = dbe;
    data_addr  = daddr;
    data_wdata = dwdata;
  endtask

  task automatic modelReset();
    owner = 0; cap_addr = '0; cap_we = 1'b0; cap_be = '0; cap_wdata = '0;
    exp_iv = 1'b0; exp_dv = 1'b0; exp_err = 1'b0; exp_ird = '0; exp_drd = '0;
    wait_left = 0; stalled = 0;
  endtask

  task automatic finishAccess(input bit timed_out);
    if (owner == 1) begin
      exp_iv  = 1'b1;
      exp_ird = timed_out ? '0 : mem_rdata;
    end else begin
      exp_dv = 1'b1;
      if (timed_out) exp_drd = '0;
      else if (!cap_we) exp_drd = mem_rdata;
    end
    exp_err = timed_out;
    cap_we  = 1'b0;
    owner   = 0;
  endtask

  task automatic modelEdge();
    exp_iv = 1'b0; exp_dv = 1'b0; exp_err = 1'b0;
    if (owner == 0) begin
      if (data_req) begin
        owner = 2; cap_addr = data_addr; cap_we = data_we; cap_be = data_be; cap_wdata = data_wdata;
      end else if (inst_req) begin
        owner = 1; cap_addr = inst_addr; cap_we = 1'b0; cap_be = '1;
      end
      if (owner != 0) begin
        wait_left = (forced_wait >= 0) ? forced_wait : $urandom_range(0, MAX_WAIT);
        stalled   = 0;
      end
    end else if (mem_ready) begin
      finishAccess(1'b0);
    end else begin
      wait_left--;
      stalled++;
      if (TO_LIM != 0 && stalled == TO_LIM) finishAccess(1'b1);
    end
  endtask

  task automatic checkAll();
    checkOutput("mem_req", 32'(mem_req), 32'(owner != 0));
    checkOutput("mem_we", 32'(mem_we), 32'(cap_we));
    checkOutput("mem_be", 32'(mem_be), 32'(cap_be));
    checkOutput("mem_addr", mem_addr, cap_addr);
    checkOutput("mem_wdata", mem_wdata, cap_wdata);
    checkOutput("inst_valid", 32'(inst_valid), 32'(exp_iv));
    checkOutput("data_valid", 32'(data_valid), 32'(exp_dv));
    checkOutput("inst_rdata", inst_rdata, exp_ird);
    checkOutput("data_rdata", data_rdata, exp_drd);
    checkOutput("stallF", 32'(stallF), 32'(inst_req & ~exp_iv));
    checkOutput("stallM", 32'(stallM), 32'(data_req & ~exp_dv));
    checkOutput("err", 32'(err), 32'(exp_err));
    reqhi_seen  += int'(mem_req === 1'b1);
    ivalid_seen += int'(inst_valid === 1'b1);
    dvalid_seen += int'(data_valid === 1'b1);
    err_seen    += int'(err === 1'b1);
  endtask

  // Drives the memory side for the coming edge, then advances and checks the model.
  task automatic runCycle();
    if (owner != 0) mem_ready = (wait_left == 0);
    else mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = force_rd_en ? force_rd : $urandom;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic runUntilIdle(input int max_cycles);
    bit drained = 1'b0;
    for (int i = 0; i < max_cycles && !drained; i++) begin
      runCycle();
      if (exp_iv) inst_req = 1'b0;
      if (exp_dv) data_req = 1'b0;
      drained = !inst_req && !data_req && owner == 0;
    end
    checkOutput("drain_bound", 32'(drained), 32'd1);
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    mem_ready = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b1;
  endtask

  task automatic clearSeen();
    reqhi_seen = 0; ivalid_seen = 0; dvalid_seen = 0; err_seen = 0;
  endtask

  task automatic pickRequests();
    if (inst_req && !exp_iv) begin
      if (owner != 1 && $urandom_range(0, 7) == 0) inst_req = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      inst_req  = 1'b1;
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end else begin
      inst_req = 1'b0;
    end
    if (data_req && !exp_dv) begin
      if (owner != 2 && $urandom_range(0, 7) == 0) data_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      data_req   = 1'b1;
      data_we    = 1'($urandom_range(0, 1));
      data_be    = 4'($urandom);
      data_addr  = $urandom & 32'hFFFF_FFFC;
      data_wdata = $urandom;
    end else begin
      data_req = 1'b0;
    end
  endtask

  initial begin
    int fetches;
    modelReset();
    clearSeen();
    #2;
    doReset();

    // Fetch only, zero wait states.
    clearSeen();
    forced_wait = 0; force_rd_en = 1'b1; force_rd = 32'h8C08_0004;
    applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, '0, '0, '0);
    runUntilIdle(8);
    checkOutput("fetch_rdata", inst_rdata, 32'h8C08_0004);
    checkOutput("fetch_req_cycles", 32'(reqhi_seen), 32'd1);
    checkOutput("fetch_valid_pulses", 32'(ivalid_seen), 32'd1);

    // Simultaneous fetch and store: store goes first.
    clearSeen();
    applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF);
    runCycle();
    checkOutput("tie_store_first_we", 32'(mem_we), 32'd1);
    checkOutput("tie_store_addr", mem_addr, 32'h0000_0010);
    runUntilIdle(10);
    checkOutput("tie_both_served", 32'(ivalid_seen + dvalid_seen), 32'd2);
    checkOutput("tie_store_keeps_rdata", data_rdata, 32'h0);

    // Load with three wait states.
    clearSeen();
    forced_wait = 3; force_rd = 32'h1234_5678;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h0000_0020, '0);
    runUntilIdle(10);
    checkOutput("wait_req_cycles", 32'(reqhi_seen), 32'd4);
    checkOutput("wait_valid_pulses", 32'(dvalid_seen), 32'd1);
    checkOutput("wait_load_rdata", data_rdata, 32'h1234_5678);

    // Reset in the middle of a data access.
    forced_wait = 10;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h0000_0040, '0);
    runCycle();
    runCycle();
    doReset();
    clearSeen();
    repeat (3) runCycle();
    checkOutput("reset_no_valid", 32'(dvalid_seen + ivalid_seen), 32'd0);

    // Three back-to-back fetches with inst_req held high.
    clearSeen();
    forced_wait = 0; force_rd_en = 1'b0; fetches = 0;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 20 && fetches < 3; i++) begin
      runCycle();
      if (exp_iv) begin
        fetches++;
        if (fetches < 3) inst_addr = inst_addr + 32'd4;
        else inst_req = 1'b0;
      end
    end
    runCycle();
    checkOutput("b2b_valid_pulses", 32'(ivalid_seen), 32'd3);
    checkOutput("b2b_req_cycles", 32'(reqhi_seen), 32'd3);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: the watchdog aborts, then a normal load follows.
    clearSeen();
    forced_wait = 100;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h0000_0080, '0);
    runUntilIdle(12);
    checkOutput("timeout_err_pulses", 32'(err_seen), 32'd1);
    checkOutput("timeout_rdata_zero", data_rdata, 32'h0);
    forced_wait = 0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'hF, 32'h0000_0084, '0);
    runUntilIdle(8);
    checkOutput("after_timeout_valids", 32'(dvalid_seen), 32'd2);
`endif

    // Randomized traffic with random wait states.
    forced_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      runCycle();
      pickRequests();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
